// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch controller for the RISC-V core. After reset it sits in a
// boot phase where an external loader writes program words into instruction
// memory. Once the loader signals completion it sequences the PC, reads the
// combinational-read instruction memory and buffers fetched words in a
// 2-entry queue toward decode (valid/ready). Branch redirects flush the
// queue; misaligned redirect targets and out-of-range fetches park the
// controller in a sticky FAULT state that only rst leaves.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_valid/addr/data/done  loader write port, honoured only in BOOT
//   imem_addr, imem_rdata    fetch address (= pc) and same-cycle read data
//   imem_we/waddr/wdata      memory write port, driven from the loader
//   redir_valid, redir_pc    branch/jump redirect request
//   if_valid/ready/instr/pc  queue head toward decode
//   fetch_err                sticky fault flag
//   state_o                  current state (BOOT=0, RUN=1, FAULT=2)
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_err,
  output logic [1:0]  state_o
);

  localparam int          QDEPTH   = 2;
  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [1:0]  count_reg, count_next;
  logic        fetch_err_reg, fetch_err_next;

  logic        head_valid;
  logic        pop;
  logic        push;
  logic        flush;
  logic [1:0]  wr_slot;

  // Queue contents as seen from outside each entry; entry 0 is the head.
  logic [31:0] ent_instr [QDEPTH];
  logic [31:0] ent_pc    [QDEPTH];

  // Count is only ever non-zero in RUN (BOOT starts empty, FAULT flushes),
  // but the state term keeps if_valid low regardless.
  assign head_valid = (state_reg == ST_RUN) && (count_reg != 2'd0);

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_BOOT;
      pc_reg        <= RESET_PC;
      count_reg     <= 2'd0;
      fetch_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      count_reg     <= count_next;
      fetch_err_reg <= fetch_err_next;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state, PC sequencing and queue control
  // ------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    fetch_err_next = fetch_err_reg;
    pop            = 1'b0;
    push           = 1'b0;
    flush          = 1'b0;

    case (state_reg)
      ST_BOOT: begin
        if (ld_done) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        // Decode's handshake completes even on a redirect or fault cycle;
        // the flush only discards what is left behind it.
        pop = head_valid && if_ready;
        if (redir_valid) begin
          flush = 1'b1;
          if (redir_pc[1:0] != 2'b00) begin
            // Misaligned target: pc stays where it was.
            state_next     = ST_FAULT;
            fetch_err_next = 1'b1;
          end else begin
            pc_next = redir_pc;
          end
        end else if ((count_reg < 2'(QDEPTH)) || pop) begin
          if (pc_reg >= PC_LIMIT) begin
            // Fetch beyond memory: the word is not enqueued.
            flush          = 1'b1;
            state_next     = ST_FAULT;
            fetch_err_next = 1'b1;
          end else begin
            push    = 1'b1;
            pc_next = pc_reg + 32'd4;
          end
        end
      end

      ST_FAULT: begin
        // Terminal until rst.
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase

    if (flush) begin
      count_next = 2'd0;
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Slot a pushed word lands in, after the head has shifted out on a pop.
  assign wr_slot = count_reg - {1'b0, pop};

  // ------------------------------------------------------------------------
  // Queue storage: shift-style FIFO, entry 0 is the head. On a pop every
  // entry takes the one behind it (the last entry keeps its stale copy,
  // which is beyond count and therefore never observed). A push overrides
  // the slot it targets. A flush leaves data untouched; count alone marks
  // entries invalid.
  // ------------------------------------------------------------------------
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
    localparam int SRC = (gi + 1 < QDEPTH) ? gi + 1 : gi;

    logic [31:0] instr_reg, instr_next;
    logic [31:0] epc_reg,   epc_next;

    always_comb begin
      instr_next = instr_reg;
      epc_next   = epc_reg;
      if (push && (wr_slot == 2'(gi))) begin
        instr_next = imem_rdata;
        epc_next   = pc_reg;
      end else if (pop) begin
        instr_next = ent_instr[SRC];
        epc_next   = ent_pc[SRC];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        instr_reg <= 32'd0;
        epc_reg   <= 32'd0;
      end else begin
        instr_reg <= instr_next;
        epc_reg   <= epc_next;
      end
    end

    assign ent_instr[gi] = instr_reg;
    assign ent_pc[gi]    = epc_reg;
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign imem_addr  = pc_reg;
  // Loader writes pass straight through in BOOT, including the ld_done cycle.
  assign imem_we    = (state_reg == ST_BOOT) && ld_valid && !rst;
  assign imem_waddr = (state_reg == ST_BOOT) ? ld_addr : 32'd0;
  assign imem_wdata = (state_reg == ST_BOOT) ? ld_data : 32'd0;

  assign if_valid   = head_valid;
  assign if_instr   = ent_instr[0];
  assign if_pc      = ent_pc[0];
  assign fetch_err  = fetch_err_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Directed bench for imem_fetch_ctrl with a 16-word instruction memory
// model (registered write, combinational read). Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;
  logic [1:0]  state_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [31:0] prog [16];
  logic [31:0] mem  [16];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .fetch_err   (fetch_err),
    .state_o     (state_o)
  );

  // Instruction memory model.
  always @(posedge clk) begin
    if (imem_we) mem[imem_waddr[3:0]] <= imem_wdata;
  end
  assign imem_rdata = (imem_addr < 32'd64) ? mem[imem_addr[5:2]] : 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    check({tag, ".valid"}, 32'(if_valid), 32'd1);
    check({tag, ".pc"}, if_pc, exp_pc);
    check({tag, ".instr"}, if_instr, prog[exp_pc[5:2]]);
  endtask

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h4011_0233;
    for (int i = 4; i < 16; i++) prog[i] = 32'h1000_0000 + 32'(i * 32'h111);

    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    redir_valid = 1'b0; redir_pc = '0; if_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst.state", 32'(state_o), 32'd0);
    check("rst.if_valid", 32'(if_valid), 32'd0);
    check("rst.fetch_err", 32'(fetch_err), 32'd0);
    check("rst.imem_addr", imem_addr, 32'd0);
    check("rst.imem_we", 32'(imem_we), 32'd0);
    rst = 1'b0;
    tick();

    // Boot load, last write shares the cycle with ld_done
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 32'(i);
      ld_data  = prog[i];
      ld_done  = (i == 15);
      #1;
      if (i == 0 || i == 15) begin
        check("boot.we", 32'(imem_we), 32'd1);
        check("boot.waddr", imem_waddr, 32'(i));
        check("boot.wdata", imem_wdata, prog[i]);
      end
      tick();
    end
    ld_valid = 1'b0; ld_done = 1'b0;
    check("boot.state_run", 32'(state_o), 32'd1);
    check("boot.no_valid_yet", 32'(if_valid), 32'd0);
    if_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check_head("boot.deliver", 32'(4 * k));
      tick();
    end

    // Fill the queue, then reset with count = 2
    if_ready = 1'b0;
    tick();
    check("fill.pc", imem_addr, 32'd24);
    tick();
    check("fill.pc_hold", imem_addr, 32'd24);
    ld_valid = 1'b1;
    #1;
    check("run.we_blocked", 32'(imem_we), 32'd0);
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst.state", 32'(state_o), 32'd0);
    check("midrst.if_valid", 32'(if_valid), 32'd0);
    check("midrst.pc", imem_addr, 32'd0);
    check("midrst.fetch_err", 32'(fetch_err), 32'd0);
    rst = 1'b0; ld_done = 1'b1;
    tick();
    ld_done = 1'b0;

    // Backpressure for 5 cycles after reboot (memory retained)
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp.pc", imem_addr, (c == 0) ? 32'd4 : 32'd8);
    end
    if_ready = 1'b1;
    check_head("bp.rel0", 32'd0);
    tick();
    check_head("bp.rel1", 32'd4);
    tick();
    check_head("bp.rel2", 32'd8);
    tick();
    check_head("bp.rel3", 32'd12);

    // Redirect to 0 from a full queue
    redir_valid = 1'b1; redir_pc = 32'd0;
    tick();
    redir_valid = 1'b0;
    check("redir0.flush", 32'(if_valid), 32'd0);
    check("redir0.pc", imem_addr, 32'd0);
    tick();
    check_head("redir0.head", 32'd0);
    tick();
    check_head("redir0.next", 32'd4);

    // Redirect at if_pc = 4 to 24
    redir_valid = 1'b1; redir_pc = 32'd24;
    tick();
    redir_valid = 1'b0;
    check("redir24.flush", 32'(if_valid), 32'd0);
    check("redir24.pc", imem_addr, 32'd24);
    tick();
    check_head("redir24.head", 32'd24);

    // Run to the end of memory
    for (int a = 28; a <= 60; a += 4) begin
      tick();
      check("seq.pc", if_pc, 32'(a));
    end
    check("seq.instr60", if_instr, prog[15]);
    check("seq.pc64", imem_addr, 32'd64);
    tick();
    check("range.state", 32'(state_o), 32'd2);
    check("range.fetch_err", 32'(fetch_err), 32'd1);
    check("range.if_valid", 32'(if_valid), 32'd0);
    check("range.pc", imem_addr, 32'd64);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("range.stuck", 32'(state_o), 32'd2);

    // Misaligned redirect
    rst = 1'b1;
    tick();
    check("rst2.fetch_err", 32'(fetch_err), 32'd0);
    rst = 1'b0; ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    tick();
    check_head("mis.head", 32'd0);
    redir_valid = 1'b1; redir_pc = 32'h0000_0006;
    tick();
    check("mis.state", 32'(state_o), 32'd2);
    check("mis.fetch_err", 32'(fetch_err), 32'd1);
    check("mis.if_valid", 32'(if_valid), 32'd0);
    check("mis.pc", imem_addr, 32'd4);
    redir_pc = 32'd8;
    tick();
    redir_valid = 1'b0;
    check("mis.pc_frozen", imem_addr, 32'd4);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
